// File: rtl/alu_pkg.sv
// ALU result pipe: shared types.
//   alu_op_e    - 3-bit opcode encoding; 3'b110 is the single illegal code.
//   alu_flags_t - status flags travelling alongside each result.
package alu_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_OR  = 3'b100,
    OP_SLT = 3'b101,
    OP_ILL = 3'b110,
    OP_SLL = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
    logic err;
  } alu_flags_t;

  function automatic logic is_legal_op(alu_op_e op);
    return op != OP_ILL;
  endfunction

endpackage

// File: rtl/alu_result_core.sv
// Combinational ALU core: computes all operations, selects the result by
// opcode and derives the status flags.
// Ports:
//   a, b    in  N      operands
//   op      in  3      opcode (alu_op_e)
//   result  out N      selected result (0 for the illegal opcode)
//   flags   out 4      {zero, carry, ovf, err}
module alu_result_core
  import alu_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  alu_op_e      op,
  output logic [N-1:0] result,
  output alu_flags_t   flags
);

  localparam int unsigned SH_W = $clog2(N);

  logic [N:0]      sum;
  logic [N:0]      diff;
  logic            slt;
  logic [SH_W-1:0] shamt;
  logic            carry;
  logic            ovf;

  // Extra MSB captures carry-out; SUB is a + ~b + 1 so bit N means "no borrow".
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
  // True signed compare, so the answer is right even when a - b overflows.
  assign slt   = $signed(a) < $signed(b);
  assign shamt = b[SH_W-1:0];

  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    unique case (op)
      OP_ADD: begin
        result = sum[N-1:0];
        carry  = sum[N];
        ovf    = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      OP_SUB: begin
        result = diff[N-1:0];
        carry  = diff[N];
        ovf    = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
      end
      OP_AND:  result = a & b;
      OP_XOR:  result = a ^ b;
      OP_OR:   result = a | b;
      OP_SLT:  result = {{(N-1){1'b0}}, slt};
      OP_SLL:  result = a << shamt;
      default: result = '0;
    endcase
  end

  always_comb begin
    flags       = '0;
    flags.zero  = (result == '0);
    flags.carry = carry;
    flags.ovf   = ovf;
    flags.err   = !is_legal_op(op);
  end

endmodule

// File: rtl/alu_result_pipe.sv
// Two-stage valid/ready ALU pipeline: operand register -> ALU core -> result
// register, with full backpressure and a saturating completion counter.
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_valid/in_ready    upstream handshake; in_a, in_b, in_op captured on transfer
//   out_valid/out_ready  downstream handshake
//   out_result           ALU result; out_zero/out_carry/out_ovf/out_err flags
//   op_count             completed output handshakes, saturates at all-ones
module alu_result_pipe
  import alu_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_result,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_err,
  output logic [CNT_W-1:0] op_count
);

  // Stage 1: operand register
  logic       s1_valid_q;
  logic [N-1:0] s1_a_q;
  logic [N-1:0] s1_b_q;
  alu_op_e    s1_op_q;

  // Stage 2: result register
  logic       out_valid_q;
  logic [N-1:0] out_result_q;
  alu_flags_t out_flags_q;

  logic [CNT_W-1:0] op_count_q;

  logic [N-1:0] core_result;
  alu_flags_t   core_flags;

  logic in_fire;
  logic s2_load;
  logic out_fire;

  alu_result_core #(
    .N (N)
  ) u_core (
    .a      (s1_a_q),
    .b      (s1_b_q),
    .op     (s1_op_q),
    .result (core_result),
    .flags  (core_flags)
  );

  // Stage 2 takes a new result whenever it is empty or draining this cycle.
  assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
  // Stage 1 can accept if empty, or if its entry moves on this cycle.
  assign in_ready = !s1_valid_q || !out_valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= OP_ADD;
    end else if (in_fire) begin
      s1_valid_q <= 1'b1;
      s1_a_q     <= in_a;
      s1_b_q     <= in_b;
      s1_op_q    <= alu_op_e'(in_op);
    end else if (s2_load) begin
      s1_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else if (s2_load) begin
      out_valid_q  <= 1'b1;
      out_result_q <= core_result;
      out_flags_q  <= core_flags;
    end else if (out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q <= '0;
    end else if (out_fire && (op_count_q != {CNT_W{1'b1}})) begin
      op_count_q <= op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_zero   = out_flags_q.zero;
  assign out_carry  = out_flags_q.carry;
  assign out_ovf    = out_flags_q.ovf;
  assign out_err    = out_flags_q.err;
  assign op_count   = op_count_q;

endmodule
